uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, rx_baud_tick pulses per bit period.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud, from baud_rate_generator.
REQ-006 rx_pin  input  1  serial line, asynchronous to clk, idle high.
REQ-007 rx_data  output  DATA_BITS  last received byte.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-010 rx_frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 rx_overrun  output  1  one-clk pulse: completed byte dropped because the buffer was full.

Function
REQ-012 rx_pin SHALL pass through a 2-flop synchronizer; all FSM logic SHALL use the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and BREAK; the tick counter (0..OVERSAMPLE-1) and bit counter (0..DATA_BITS-1) SHALL advance only on rx_baud_tick.
REQ-014 IDLE: rx_s low on a tick -> START with tick counter cleared.
REQ-015 START: at tick count OVERSAMPLE/2-1 (mid start bit), rx_s low -> DATA with counters cleared; rx_s high -> IDLE (glitch rejected, no outputs).
REQ-016 DATA: every OVERSAMPLE ticks, sample rx_s into the shift register, LSB first; after DATA_BITS samples -> STOP.
REQ-017 STOP: OVERSAMPLE ticks later, sample mid stop bit; high -> byte complete, go to IDLE; low -> rx_frame_err pulse, byte discarded, go to BREAK.
REQ-018 BREAK: remain until rx_s is high on a tick, then IDLE.
REQ-019 On byte complete with rx_valid low, rx_data SHALL load and rx_valid SHALL assert on the next clk edge (latency: 1 clk after the stop-bit sample tick).
REQ-020 rx_valid && rx_ready SHALL clear rx_valid on the next edge; rx_data SHALL hold its value.
REQ-021 Byte complete while rx_valid high and rx_ready low -> rx_overrun pulse; rx_data and rx_valid SHALL be unchanged (new byte dropped).
REQ-022 Byte complete in the same cycle as rx_valid && rx_ready -> new byte loaded, rx_valid stays high, no overrun.
REQ-023 rx_frame_err and rx_overrun SHALL never be high for more than one consecutive clk.
REQ-024 The receiver SHALL tolerate consecutive frames with a single stop bit and no idle gap.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, counters 0, shift register 0, rx_data 0, rx_valid 0, rx_frame_err 0, rx_overrun 0, synchronizer flops 1.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no output; after release, reception SHALL resume at the next start bit.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encoding, the OVERSAMPLE default and the DATA_BITS default, for reuse by the transmitter.
REQ-028 The synchronizer SHALL be a sub-module uart_rx_sync (2 flops, reset value 1); all other logic SHALL live in uart_receiver.

Verification (50 MHz clk, 115200 baud, baud_rate_generator driving rx_baud_tick; uart_transmitter as stimulus source where noted)
REQ-029 uart_transmitter sends 0x55 into rx_pin with rx_ready=1 -> one rx_valid pulse with rx_data=0x55; rx_frame_err=0, rx_overrun=0.
REQ-030 Back-to-back 0xB4 then 0xA2 with no idle gap and rx_ready=1 -> rx_data 0xB4 then 0xA2, each qualified by rx_valid; no errors.
REQ-031 rx_pin low for 4 ticks, then high -> no rx_valid and no error; the FSM returns to IDLE, and a following 0x3C is received correctly.
REQ-032 Frame 0xAA with stop bit forced low -> rx_frame_err pulses once and rx_valid stays 0; once the line returns high, 0x0F is received correctly.
REQ-033 rx_ready=0, frames 0x11 then 0x22 -> rx_valid high with rx_data=0x11, one rx_overrun pulse at the end of 0x22; after rx_ready=1 for one clk, rx_valid drops.
REQ-034 rst pulsed during data bit 3 of 0x99 -> all outputs 0 immediately and no byte delivered; the next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver state encoding.
package uart_pkg;

   localparam int UART_DATA_BITS_DEF  = 8;
   localparam int UART_OVERSAMPLE_DEF = 16;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; flops idle high.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_pin,
   output logic rx_s
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values simply shift the line one stage down the chain.
   always_comb begin
      meta_d = rx_pin;
      sync_d = meta_q;
   end

   // Synchronizer register pair, reset to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign rx_s = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with a one-entry output buffer and error pulses.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS_DEF,
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_baud_tick,
   input  logic                 rx_pin,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 byte_done;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .rx_pin (rx_pin),
      .rx_s   (rx_s)
   );

   // Frame FSM: all counting and sampling happens only on baud ticks.
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      if (rx_baud_tick) begin
         case (state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  state_d    = RX_START;
                  tick_cnt_d = '0;
               end
            end
            RX_START: begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            RX_DATA: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
                     state_d   = RX_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            RX_STOP: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  if (rx_s) begin
                     byte_done = 1'b1;
                     state_d   = RX_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = RX_BREAK;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            RX_BREAK: begin
               if (rx_s) begin
                  state_d = RX_IDLE;
               end
            end
            default: begin
               state_d    = RX_IDLE;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
            end
         endcase
      end
   end

   // Output buffer: load a finished byte if there is room, else flag overrun.
   // A handshake in the same cycle as a new byte frees the slot for it.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (byte_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   // State, counters, data buffer and error pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RX_IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = frame_err_q;
   assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are bit-banged onto rx_pin.
module tb_uart_receiver;

   localparam int OS       = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = OS * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_baud_tick = 1'b0;
   logic       rx_pin = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       rx_frame_err;
   logic       rx_overrun;

   int total = 0;
   int bad   = 0;

   logic [7:0] got[$];
   int valid_cycles = 0;
   int err_pulses   = 0;
   int ovr_pulses   = 0;
   int pulse_viol   = 0;
   logic prev_err = 1'b0;
   logic prev_ovr = 1'b0;

   uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_baud_tick (rx_baud_tick),
      .rx_pin       (rx_pin),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   // 100 MHz system clock.
   always #5 clk = ~clk;

   // Baud tick: one clock high out of every TICK_DIV clocks.
   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(posedge clk);
         #1 rx_baud_tick = 1'b1;
         @(posedge clk);
         #1 rx_baud_tick = 1'b0;
      end
   end

   // Monitor on the falling edge: accepted bytes, pulse counts, pulse widths.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) got.push_back(rx_data);
         if (rx_valid) valid_cycles++;
         if (rx_frame_err) err_pulses++;
         if (rx_overrun) ovr_pulses++;
         if ((rx_frame_err && prev_err) || (rx_overrun && prev_ovr)) pulse_viol++;
         prev_err = rx_frame_err;
         prev_ovr = rx_overrun;
      end else begin
         prev_err = 1'b0;
         prev_ovr = 1'b0;
      end
   end

   task automatic send_bit(input logic b);
      rx_pin = b;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      rx_pin = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", rx_valid); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", rx_data); end
      total++; if ({rx_frame_err, rx_overrun} !== 2'b00) begin bad++; $display("[TB] FAIL reset_errs got=%b want=00", {rx_frame_err, rx_overrun}); end
      @(posedge clk); #1 rst = 1'b0;
      idle(2 * BIT_CLKS);
   endtask

   task automatic test_single();
      int base = got.size();
      int vc = valid_cycles;
      send_frame(8'h55, 1'b1);
      idle(BIT_CLKS);
      total++; if (got.size() !== base + 1) begin bad++; $display("[TB] FAIL single_count got=%0d want=%0d", got.size(), base + 1); end
      else begin
         total++; if (got[base] !== 8'h55) begin bad++; $display("[TB] FAIL single_data got=%h want=55", got[base]); end
      end
      total++; if (valid_cycles - vc !== 1) begin bad++; $display("[TB] FAIL single_valid_width got=%0d want=1", valid_cycles - vc); end
      total++; if (err_pulses !== 0) begin bad++; $display("[TB] FAIL single_ferr got=%0d want=0", err_pulses); end
      total++; if (ovr_pulses !== 0) begin bad++; $display("[TB] FAIL single_ovr got=%0d want=0", ovr_pulses); end
   endtask

   task automatic test_back_to_back();
      int base = got.size();
      send_frame(8'hB4, 1'b1);
      send_frame(8'hA2, 1'b1);
      idle(BIT_CLKS);
      total++; if (got.size() !== base + 2) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", got.size(), base + 2); end
      else begin
         total++; if (got[base] !== 8'hB4) begin bad++; $display("[TB] FAIL b2b_first got=%h want=b4", got[base]); end
         total++; if (got[base+1] !== 8'hA2) begin bad++; $display("[TB] FAIL b2b_second got=%h want=a2", got[base+1]); end
      end
      total++; if (err_pulses + ovr_pulses !== 0) begin bad++; $display("[TB] FAIL b2b_errs got=%0d want=0", err_pulses + ovr_pulses); end
   endtask

   task automatic test_glitch();
      int base = got.size();
      int vc = valid_cycles;
      rx_pin = 1'b0;
      repeat (4 * TICK_DIV) @(posedge clk);
      #1;
      idle(3 * BIT_CLKS);
      total++; if (valid_cycles !== vc) begin bad++; $display("[TB] FAIL glitch_valid got=%0d want=%0d", valid_cycles, vc); end
      total++; if (err_pulses !== 0) begin bad++; $display("[TB] FAIL glitch_ferr got=%0d want=0", err_pulses); end
      send_frame(8'h3C, 1'b1);
      idle(BIT_CLKS);
      total++; if (got.size() !== base + 1) begin bad++; $display("[TB] FAIL glitch_next_count got=%0d want=%0d", got.size(), base + 1); end
      else begin
         total++; if (got[base] !== 8'h3C) begin bad++; $display("[TB] FAIL glitch_next_data got=%h want=3c", got[base]); end
      end
   endtask

   task automatic test_frame_err();
      int base = got.size();
      int vc = valid_cycles;
      int ec = err_pulses;
      send_frame(8'hAA, 1'b0);
      idle(2 * BIT_CLKS);
      total++; if (err_pulses - ec !== 1) begin bad++; $display("[TB] FAIL ferr_pulses got=%0d want=1", err_pulses - ec); end
      total++; if (valid_cycles !== vc) begin bad++; $display("[TB] FAIL ferr_valid got=%0d want=%0d", valid_cycles, vc); end
      send_frame(8'h0F, 1'b1);
      idle(BIT_CLKS);
      total++; if (got.size() !== base + 1) begin bad++; $display("[TB] FAIL ferr_next_count got=%0d want=%0d", got.size(), base + 1); end
      else begin
         total++; if (got[base] !== 8'h0F) begin bad++; $display("[TB] FAIL ferr_next_data got=%h want=0f", got[base]); end
      end
   endtask

   task automatic test_overrun();
      int base = got.size();
      int oc = ovr_pulses;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(BIT_CLKS);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_valid got=%b want=1", rx_valid); end
      total++; if (rx_data !== 8'h11) begin bad++; $display("[TB] FAIL ovr_data got=%h want=11", rx_data); end
      total++; if (ovr_pulses - oc !== 1) begin bad++; $display("[TB] FAIL ovr_pulses got=%0d want=1", ovr_pulses - oc); end
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_drain got=%b want=0", rx_valid); end
      total++; if (got.size() !== base + 1 || got[got.size()-1] !== 8'h11) begin bad++; $display("[TB] FAIL ovr_accept got=%0d want=1 byte 11", got.size() - base); end
      rx_ready = 1'b1;
      idle(BIT_CLKS);
   endtask

   task automatic test_reset_midframe();
      int base;
      logic [7:0] d = 8'h99;
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1);
      idle(BIT_CLKS);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_pre_valid got=%b want=1", rx_valid); end
      base = got.size();
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      rx_pin = d[3];
      repeat (BIT_CLKS / 2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b want=0", rx_valid); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data got=%h want=00", rx_data); end
      total++; if ({rx_frame_err, rx_overrun} !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_errs got=%b want=00", {rx_frame_err, rx_overrun}); end
      rx_pin = 1'b1;
      rx_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      idle(2 * BIT_CLKS);
      send_frame(8'h3C, 1'b1);
      idle(BIT_CLKS);
      total++; if (got.size() !== base + 1) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=%0d", got.size(), base + 1); end
      else begin
         total++; if (got[base] !== 8'h3C) begin bad++; $display("[TB] FAIL rstmid_next_data got=%h want=3c", got[base]); end
      end
   endtask

   task automatic test_pulse_width();
      total++; if (pulse_viol !== 0) begin bad++; $display("[TB] FAIL pulse_width got=%0d want=0", pulse_viol); end
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_midframe();
      test_pulse_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
